// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl
// Purpose  : Byte-addressed, multi-cycle data memory for the load/store path.
//            Supports byte/half/word(/double) accesses, sign/zero-extended
//            loads, LAT wait states and a req/ready/done handshake.
//            Misaligned or illegal-size requests complete with fault=1 and
//            make no memory access.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1  clock, rising edge
//   rst          in   1  asynchronous active-high reset (also clears mem)
//   req          in   1  request valid, sampled when ready=1
//   we           in   1  1 = store, 0 = load
//   addr         in   N  byte address
//   size         in   2  00 byte, 01 half, 10 word, 11 double (W=64 only)
//   unsigned_ld  in   1  1 = zero-extend load, 0 = sign-extend
//   wdata        in   W  right-aligned store data
//   ready        out  1  request can be accepted this cycle
//   done         out  1  one-cycle completion pulse
//   rdata        out  W  load result, valid with done
//   fault        out  1  access aborted, valid with done
// ============================================================================
module data_memory_ctrl #(
    parameter int W   = 32,
    parameter int N   = 7,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         we,
    input  logic [N-1:0] addr,
    input  logic [1:0]   size,
    input  logic         unsigned_ld,
    input  logic [W-1:0] wdata,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] rdata,
    output logic         fault
);

    localparam int BYTES = W / 8;
    localparam int LOG2B = $clog2(BYTES);
    localparam int DEPTH = (2 ** N) / BYTES;
    localparam int WA_W  = N - LOG2B;

    localparam logic [3:0] C_LAT = 4'(LAT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [W-1:0]     rdata_q, rdata_d;
    logic             fault_q, fault_d;

    logic             we_q;
    logic [N-1:0]     addr_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [W-1:0]     wdata_q;

    logic [W-1:0]     mem [DEPTH];

    // ------------------------------------------------------------------
    // Request classification (on the live inputs, used at accept)
    // ------------------------------------------------------------------
    logic             accept;
    logic             size_bad;
    logic [N-1:0]     align_mask;
    logic             misalign;
    logic             req_bad;

    assign accept     = req && ready;
    assign size_bad   = (int'(size) > LOG2B);
    assign align_mask = (N'(1) << size) - N'(1);
    assign misalign   = |(addr & align_mask);
    assign req_bad    = size_bad || misalign;

    // ------------------------------------------------------------------
    // Access datapath (on the captured request)
    // ------------------------------------------------------------------
    logic [LOG2B-1:0] lane;
    logic [WA_W-1:0]  widx;
    logic [W-1:0]     word;
    logic [LOG2B+2:0] shamt;
    logic [W-1:0]     rsh;
    logic [W-1:0]     wsh;
    logic [W-1:0]     size_mask;
    logic             sign_bit;
    logic [W-1:0]     load_val;
    logic [BYTES-1:0] be_base;
    logic [BYTES-1:0] be;
    logic [W-1:0]     bit_mask;
    logic             access;

    assign lane  = addr_q[LOG2B-1:0];
    assign widx  = addr_q[N-1:LOG2B];
    assign word  = mem[widx];
    assign shamt = {lane, 3'b000};
    assign rsh   = word >> shamt;
    assign wsh   = wdata_q << shamt;

    always_comb begin
        size_mask = '1;
        sign_bit  = rsh[W-1];
        be_base   = '1;
        case (size_q)
            2'd0: begin
                size_mask = W'(8'hFF);
                sign_bit  = rsh[7];
                be_base   = BYTES'(8'h01);
            end
            2'd1: begin
                size_mask = W'(16'hFFFF);
                sign_bit  = rsh[15];
                be_base   = BYTES'(8'h03);
            end
            2'd2: begin
                size_mask = W'(32'hFFFF_FFFF);
                sign_bit  = rsh[31];
                be_base   = BYTES'(8'h0F);
            end
            default: begin
                size_mask = '1;
                sign_bit  = rsh[W-1];
                be_base   = '1;
            end
        endcase
    end

    // For a full-width load size_mask is all ones, so ~size_mask is zero and
    // the extension term vanishes regardless of unsigned_ld.
    assign load_val = (rsh & size_mask) |
                      ((sign_bit && !uns_q) ? ~size_mask : '0);

    assign be = be_base << lane;

    always_comb begin
        bit_mask = '0;
        for (int b = 0; b < BYTES; b++) begin
            bit_mask[8*b +: 8] = {8{be[b]}};
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    state_d = req_bad ? S_RESP : S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready = (state_q != S_BUSY) && !rst;
        done  = (state_q == S_RESP);
        rdata = rdata_q;
        fault = fault_q;
    end

    // ------------------------------------------------------------------
    // Counter / response next values. rdata and fault default to 0 so they
    // only hold a value during the single RESP cycle that follows.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        rdata_d = '0;
        fault_d = 1'b0;
        access  = 1'b0;
        if (accept) begin
            if (req_bad) begin
                fault_d = 1'b1;
            end else begin
                cnt_d = C_LAT;
            end
        end else if (state_q == S_BUSY) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                access = 1'b1;
                if (!we_q) begin
                    rdata_d = load_val;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers and memory array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                size_q  <= size;
                uns_q   <= unsigned_ld;
                wdata_q <= wdata;
            end
            if (access && we_q) begin
                mem[widx] <= (word & ~bit_mask) | (wsh & bit_mask);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ctrl
// Purpose  : Directed self-checking bench for data_memory_ctrl (W=32, N=7,
//            LAT=2). Expected values are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

    localparam int W   = 32;
    localparam int N   = 7;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [N-1:0] addr = '0;
    logic [1:0]   size = '0;
    logic         unsigned_ld = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] rdata;
    logic         fault;

    int total = 0;
    int bad   = 0;

    data_memory_ctrl #(.W(W), .N(N), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .wdata       (wdata),
        .ready       (ready),
        .done        (done),
        .rdata       (rdata),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, then count cycles until done (accept cycle = 1).
    task automatic access(input string tag, input logic w, input logic [N-1:0] a,
                          input logic [1:0] s, input logic u, input logic [W-1:0] wd,
                          input logic [W-1:0] exp_rd, input logic exp_f, input int exp_lat);
        int n;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; size = s; unsigned_ld = u; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"},   64'(n),      64'(exp_lat));
        chk({tag, "_rdata"}, 64'(rdata),  64'(exp_rd));
        chk({tag, "_fault"}, 64'(fault),  64'(exp_f));
    endtask

    initial begin
        int nz;
        int seen;
        int n;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1 chk("rst_rel_ready", 64'(ready), 64'd1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;                       // mid-cycle pulse
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        @(negedge clk); rst = 1'b0;
        #1 chk("rst_ready_after", 64'(ready), 64'd1);
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.mem[i] !== 32'h0) nz++;
        chk("rst_mem_clear", 64'(nz), 64'd0);

        // ---------------- word store / load ----------------
        access("sw10",  1'b1, 7'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 4);
        access("lw10",  1'b0, 7'h10, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 4);

        // ---------------- byte store, signed/unsigned loads ----------------
        access("sb13",  1'b1, 7'h13, 2'd0, 1'b0, 32'h12345680, 32'h0,        1'b0, 4);
        access("lb13",  1'b0, 7'h13, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 4);
        access("lbu13", 1'b0, 7'h13, 2'd0, 1'b1, 32'h0,        32'h00000080, 1'b0, 4);
        access("lw10b", 1'b0, 7'h10, 2'd2, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0, 4);

        // ---------------- half store / loads ----------------
        access("sh12",  1'b1, 7'h12, 2'd1, 1'b0, 32'hABCD1234, 32'h0,        1'b0, 4);
        access("lh12",  1'b0, 7'h12, 2'd1, 1'b0, 32'h0,        32'h00001234, 1'b0, 4);
        access("lw10c", 1'b0, 7'h10, 2'd2, 1'b0, 32'h0,        32'h1234BEEF, 1'b0, 4);
        access("lh10",  1'b0, 7'h10, 2'd1, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0, 4);
        access("lhu10", 1'b0, 7'h10, 2'd1, 1'b1, 32'h0,        32'h0000BEEF, 1'b0, 4);
        access("lwu10", 1'b0, 7'h10, 2'd2, 1'b1, 32'h0,        32'h1234BEEF, 1'b0, 4);

        // ---------------- req held high through BUSY ----------------
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 7'h10; size = 2'd2; unsigned_ld = 1'b0;
        @(posedge clk); #1;
        addr = 7'h11; size = 2'd0; unsigned_ld = 1'b1;   // must wait for RESP
        @(posedge clk); #1;
        chk("held_b1_done",  64'(done),  64'd0);
        chk("held_b1_ready", 64'(ready), 64'd0);
        @(posedge clk); #1;
        chk("held_b2_done",  64'(done),  64'd0);
        @(posedge clk); #1;
        chk("held_resp_done",  64'(done),  64'd1);
        chk("held_resp_rdata", 64'(rdata), 64'h1234BEEF);
        @(posedge clk); #1;
        req = 1'b0;
        chk("held_acc2_done",  64'(done),  64'd0);
        chk("held_acc2_rdata", 64'(rdata), 64'd0);
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held2_lat",   64'(n),     64'd4);
        chk("held2_rdata", 64'(rdata), 64'h000000BE);

        // ---------------- faults ----------------
        access("f_lw11",  1'b0, 7'h11, 2'd2, 1'b0, 32'h0,        32'h0, 1'b1, 1);
        access("f_sh13",  1'b1, 7'h13, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        access("f_sz3",   1'b1, 7'h00, 2'd3, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        access("f_chk10", 1'b0, 7'h10, 2'd2, 1'b0, 32'h0, 32'h1234BEEF, 1'b0, 4);
        access("f_chk00", 1'b0, 7'h00, 2'd2, 1'b0, 32'h0, 32'h0,        1'b0, 4);

        // ---------------- top-of-memory boundary ----------------
        access("sw7c", 1'b1, 7'h7C, 2'd2, 1'b0, 32'h89ABCDEF, 32'h0,        1'b0, 4);
        access("lb7f", 1'b0, 7'h7F, 2'd0, 1'b0, 32'h0,        32'hFFFFFF89, 1'b0, 4);

        // ---------------- reset during BUSY ----------------
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 7'h20; size = 2'd2; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_done",  64'(done),  64'd0);
        chk("abort_ready", 64'(ready), 64'd0);
        @(posedge clk); #1;
        chk("abort_mem8",  64'(dut.mem[8]),  64'd0);
        chk("abort_mem31", 64'(dut.mem[31]), 64'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        access("abort_lw20", 1'b0, 7'h20, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 4);
        access("abort_lw10", 1'b0, 7'h10, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 4);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
